demod_accumulator: RTL and testbench



---
 rtl/demod_accumulator.sv | 94 +++++++++
 tb/tb_demod_accumulator.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/demod_accumulator.sv
// demod_accumulator: integrates signed multiplier products over a programmable window
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, num_samples  arm a window of num_samples samples (0 is ignored)
//   write_enable_in     sample strobe, delayed WE_DELAY cycles to align with product_in
//   product_in          signed product from the multiplier stage
//   acc_out, acc_valid  window sum, held until acc_valid & acc_ready
//   acc_ready           downstream accept
//   busy                window in progress or result pending
//   sample_drop         sticky: a sample arrived while a result was pending
module demod_accumulator #(
    parameter int PRODUCT_WIDTH = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int ACC_WIDTH     = 48,
    parameter int WE_DELAY      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   num_samples,
    input  logic                     write_enable_in,
    input  logic [PRODUCT_WIDTH-1:0] product_in,
    output logic [ACC_WIDTH-1:0]     acc_out,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic                     busy,
    output logic                     sample_drop
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state, state_nxt;
    logic we_d;
    logic [ACC_WIDTH-1:0] acc, sum;
    logic [COUNT_WIDTH-1:0] cnt, n_lat;
    logic start_ok, hs, last, arm;
    generate
        if (WE_DELAY == 0) begin : g_nodly
            assign we_d = write_enable_in;
        end else begin : g_dly
            logic [WE_DELAY-1:0] sr;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) sr <= '0;
                else sr <= WE_DELAY'({sr, write_enable_in});
            assign we_d = sr[WE_DELAY-1];
        end
    endgenerate
    assign sum      = acc + ACC_WIDTH'($signed(product_in));
    assign start_ok = start && (num_samples != '0);
    assign hs       = acc_valid && acc_ready;
    // counter compares against N-1 so N = 2^COUNT_WIDTH-1 never wraps
    assign last     = (state == ACCUM) && we_d && (cnt == n_lat - COUNT_WIDTH'(1));
    // a start is honoured from IDLE, or from HOLD in the handshake cycle
    assign arm      = start_ok && (state == IDLE || (state == HOLD && hs));
    assign busy     = (state != IDLE);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arm ? ACCUM : IDLE;
            ACCUM:   state_nxt = last ? HOLD : ACCUM;
            HOLD:    state_nxt = hs ? (arm ? ACCUM : IDLE) : HOLD;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            n_lat       <= '0;
            acc_out     <= '0;
            acc_valid   <= 1'b0;
            sample_drop <= 1'b0;
        end else begin
            if (state == ACCUM && we_d) begin
                acc <= sum;
                cnt <= cnt + COUNT_WIDTH'(1);
            end
            if (last) begin
                acc_out   <= sum;
                acc_valid <= 1'b1;
            end
            if (state == HOLD && we_d) sample_drop <= 1'b1;
            if (hs) acc_valid <= 1'b0;
            // an accepted start overrides a drop flagged in the same cycle
            if (arm) begin
                n_lat       <= num_samples;
                acc         <= '0;
                cnt         <= '0;
                sample_drop <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_demod_accumulator.sv
// tb_demod_accumulator: scoreboard bench for demod_accumulator
module tb_demod_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_samples = '0;
    logic        write_enable_in = 1'b0;
    logic [31:0] product_in = '0;
    logic [47:0] acc_out;
    logic        acc_valid;
    logic        acc_ready = 1'b0;
    logic        busy;
    logic        sample_drop;
    int n_cmp = 0;
    int n_err = 0;
    logic [47:0] exp_q[$];
    int prod_q[$];
    int pend = 0;
    logic pv = 1'b0;
    logic [47:0] po = '0;
    demod_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .write_enable_in(write_enable_in), .product_in(product_in),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .busy(busy), .sample_drop(sample_drop)
    );
    always #5 clk = ~clk;
    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask
    // product for a strobe appears one cycle later, matching the multiplier latency
    task automatic step(bit we, int p, bit st, logic [15:0] ns, bit rdy);
        start = st;
        num_samples = ns;
        write_enable_in = we;
        product_in = pend;
        pend = p;
        acc_ready = rdy;
        @(posedge clk);
        #1;
    endtask
    task automatic run_window(int n, int gap, int rdy_wait, bit strobe, bit poke, bit skip_start, int next_n);
        int ps[$];
        longint s = 0;
        for (int k = 0; k < n; k++) begin
            int p;
            p = (prod_q.size() != 0) ? prod_q.pop_front() : int'($urandom);
            ps.push_back(p);
            s += longint'(p);
        end
        exp_q.push_back(s[47:0]);
        if (!skip_start) begin
            step(0, 0, 1, 16'(n), 0);
            check("start_busy", busy, 1);
            check("start_drop_clr", sample_drop, 0);
        end
        foreach (ps[k]) begin
            repeat (gap) step(0, 0, poke, 16'd1, 0);
            step(1, ps[k], 0, 0, 0);
        end
        check("valid_early", acc_valid, 0);
        step(0, 0, 0, 0, 0);
        check("valid_latency", acc_valid, 1);
        for (int k = 0; k < rdy_wait; k++) step(strobe, int'($urandom), 0, 0, 0);
        if (strobe && rdy_wait > 1) check("drop_sticky", sample_drop, 1);
        step(0, 0, next_n != 0, 16'(next_n), 1);
        check("valid_fall", acc_valid, 0);
        check("busy_after", busy, next_n != 0);
        if (next_n != 0) check("b2b_drop_clr", sample_drop, 0);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv && acc_valid) check("hold_stable", acc_out, po);
            if (acc_valid && acc_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", acc_out, 48'hx);
                else check("acc_out", acc_out, exp_q.pop_front());
            end
            pv = acc_valid && !acc_ready;
            po = acc_out;
        end else pv = 1'b0;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        int carry = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acc_out", acc_out, 0);
        check("rst_valid", acc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", sample_drop, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        prod_q = '{100, -50, 7, -3};
        run_window(4, 0, 0, 0, 0, 0, 0);
        prod_q = '{int'(32'h80000000), int'(32'h80000000), int'(32'h80000000)};
        run_window(3, 0, 1, 0, 0, 0, 0);
        prod_q = '{32'h7FFFFFFF, 32'h7FFFFFFF};
        run_window(2, 0, 0, 0, 0, 0, 0);
        prod_q = '{5, 6};
        run_window(2, 0, 10, 1, 0, 0, 0);
        step(0, 0, 1, 16'd0, 0);
        check("zero_n_idle", busy, 0);
        step(0, 0, 0, 0, 0);
        check("zero_n_idle2", busy, 0);
        prod_q = '{1000, -2000, 30};
        run_window(3, 0, 0, 0, 0, 0, 2);
        prod_q = '{41, 1};
        run_window(2, 0, 0, 0, 0, 1, 0);
        prod_q = '{-7, 8, 9};
        run_window(3, 5, 0, 0, 1, 0, 0);
        step(0, 0, 1, 16'd4, 0);
        step(1, 11, 0, 0, 0);
        step(1, 22, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc_out", acc_out, 0);
        check("mid_rst_valid", acc_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drop", sample_drop, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend = 0;
        step(0, 0, 0, 0, 0);
        prod_q = '{9};
        run_window(1, 0, 1, 0, 0, 0, 0);
        run_window(300, 0, 2, 0, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            int n, nxt;
            n = (carry != 0) ? carry : int'($urandom_range(1, 8));
            nxt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_window(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), carry != 0, nxt);
            carry = nxt;
        end
        if (carry != 0) run_window(carry, 0, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        check("queue_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
